// File: rtl/arinc429_pkg.sv
// Shared ARINC 429 definitions used by the transmit and receive paths.
package arinc429_pkg;

    localparam int ARINC429_WORD_W     = 32;
    localparam int ARINC429_MIN_PERIOD = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DATA_ON   = 2'd1,
        DATA_NULL = 2'd2,
        GAP       = 2'd3
    } tx_state_t;

    // Bit that makes {parity, data} carry an odd number of ones.
    function automatic logic arinc429_odd_parity(input logic [30:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/arinc429_tx_timer.sv
// Bit timing for the ARINC 429 transmitter: half/full bit ticks and the
// inter-word gap countdown, all measured in periods of the latched P.
module arinc429_tx_timer #(
    parameter int unsigned GAP_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] period_i,
    input  logic        start_i,
    input  logic        gap_start_i,
    output logic        half_tick_o,
    output logic        bit_tick_o,
    output logic        gap_done_o
);

    logic [15:0] phase_q;
    logic [15:0] gap_left_q;
    logic        active_q;
    logic [15:0] half_s;

    assign half_s      = period_i >> 1;
    assign half_tick_o = active_q && (phase_q == (half_s - 16'd1));
    assign bit_tick_o  = active_q && (phase_q == (period_i - 16'd1));
    assign gap_done_o  = bit_tick_o && (gap_left_q == 16'd1);

    // Phase restarts on every bit boundary; the gap counter only runs once loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= 16'd0;
            gap_left_q <= 16'd0;
            active_q   <= 1'b0;
        end else if (start_i) begin
            phase_q    <= 16'd0;
            gap_left_q <= 16'd0;
            active_q   <= 1'b1;
        end else if (active_q) begin
            phase_q <= bit_tick_o ? 16'd0 : (phase_q + 16'd1);
            if (gap_start_i) begin
                gap_left_q <= 16'(GAP_BITS);
            end else if (bit_tick_o && (gap_left_q != 16'd0)) begin
                gap_left_q <= gap_left_q - 16'd1;
            end
            if (gap_done_o) begin
                active_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/arinc429_tx.sv
// ARINC 429 transmitter: bipolar RZ, LSB first, followed by a NULL gap.
// Define ARINC429_TX_PARITY_EN to replace bit 31 with odd parity over bits 30:0.
module arinc429_tx #(
    parameter int unsigned GAP_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bit_period,
    input  logic [31:0] tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        line_hi,
    output logic        line_lo,
    output logic        busy
);
    import arinc429_pkg::*;

    tx_state_t                  state_q;
    logic [ARINC429_WORD_W-1:0] shift_q;
    logic [15:0]                period_q;
    logic [4:0]                 bit_idx_q;
    logic                       tx_ready_q;
    logic                       busy_q;
    logic                       line_hi_q;
    logic                       line_lo_q;

    logic                       accept_s;
    logic                       last_bit_s;
    logic                       gap_start_s;
    logic                       half_tick_s;
    logic                       bit_tick_s;
    logic                       gap_done_s;
    logic [15:0]                period_d;
    logic [ARINC429_WORD_W-1:0] word_d;

    assign accept_s    = tx_valid && tx_ready_q;
    assign last_bit_s  = (bit_idx_q == 5'(ARINC429_WORD_W - 1));
    assign gap_start_s = (state_q == DATA_NULL) && bit_tick_s && last_bit_s;

    // Word and period as they will be latched on accept.
    always_comb begin
        period_d = (bit_period < 16'(ARINC429_MIN_PERIOD)) ? 16'(ARINC429_MIN_PERIOD) : bit_period;
`ifdef ARINC429_TX_PARITY_EN
        word_d = {arinc429_odd_parity(tx_data[30:0]), tx_data[30:0]};
`else
        word_d = tx_data;
`endif
    end

    arinc429_tx_timer #(
        .GAP_BITS(GAP_BITS)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .period_i   (period_q),
        .start_i    (accept_s),
        .gap_start_i(gap_start_s),
        .half_tick_o(half_tick_s),
        .bit_tick_o (bit_tick_s),
        .gap_done_o (gap_done_s)
    );

    // Line outputs are loaded on the same edge as the state change they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            period_q   <= 16'(ARINC429_MIN_PERIOD);
            bit_idx_q  <= 5'd0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            line_hi_q  <= 1'b0;
            line_lo_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_ready_q <= ~accept_s;
                    busy_q     <= accept_s;
                    if (accept_s) begin
                        shift_q   <= word_d;
                        period_q  <= period_d;
                        bit_idx_q <= 5'd0;
                        line_hi_q <= word_d[0];
                        line_lo_q <= ~word_d[0];
                        state_q   <= DATA_ON;
                    end
                end
                DATA_ON: begin
                    if (half_tick_s) begin
                        line_hi_q <= 1'b0;
                        line_lo_q <= 1'b0;
                        state_q   <= DATA_NULL;
                    end
                end
                DATA_NULL: begin
                    if (bit_tick_s) begin
                        if (last_bit_s) begin
                            state_q <= GAP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 5'd1;
                            shift_q   <= {1'b0, shift_q[ARINC429_WORD_W-1:1]};
                            line_hi_q <= shift_q[1];
                            line_lo_q <= ~shift_q[1];
                            state_q   <= DATA_ON;
                        end
                    end
                end
                GAP: begin
                    if (gap_done_s) begin
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    line_hi_q  <= 1'b0;
                    line_lo_q  <= 1'b0;
                    tx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign line_hi  = line_hi_q;
    assign line_lo  = line_lo_q;

endmodule
